// File: rtl/seg7_display_scheduler.sv
// seg7_display_scheduler: shares a 4-digit 7-segment display between two pattern sources
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             display enable; low blanks the display and releases any grant
//   req[1:0]       per-source display request
//   pat0, pat1     per-source cathode patterns, [31:24]=digit0 .. [7:0]=digit3
//   gnt[1:0]       one-hot grant, 00 when idle
//   anodes         active-low digit select
//   cathodes       active-low segments {dp,g..a}
//   always_off_an  constant 1111 for the unused upper digits
//   frame_done     1-cycle pulse after the digit-3 slot ends
module seg7_display_scheduler #(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  req,
    input  logic [31:0] pat0,
    input  logic [31:0] pat1,
    output logic [1:0]  gnt,
    output logic [3:0]  anodes,
    output logic [7:0]  cathodes,
    output logic [3:0]  always_off_an,
    output logic        frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc;
    logic [1:0]    digit;
    logic [HW-1:0] hold_cnt;
    logic          rr_last;
    logic          live;
    logic          tick, boundary, owner, mine, other, show;
    logic [31:0]   cur;
    logic [7:0]    seg;

    assign tick          = presc == PW'(SCAN_DIV - 1);
    assign boundary      = tick && digit == 2'd3;
    assign owner         = state == OWN1;
    assign mine          = req[owner];
    assign other         = req[~owner];
    // live marks that the owner has been shown from digit 0 of the current frame;
    // a grant taken mid-frame or a dropped request keeps the cathodes dark until the next frame
    assign show          = state != IDLE && live && mine;
    assign cur           = owner ? pat1 : pat0;
    assign seg           = digit == 2'd0 ? cur[31:24] : digit == 2'd1 ? cur[23:16] :
                           digit == 2'd2 ? cur[15:8] : cur[7:0];
    assign gnt           = {state == OWN1, state == OWN0};
    assign always_off_an = 4'hF;

    always_comb begin
        state_nx = state;
        if (state == IDLE) begin
            if (req[0] && (!req[1] || rr_last))
                state_nx = OWN0;
            else if (req[1])
                state_nx = OWN1;
        end else if (boundary) begin
            if (!mine)
                state_nx = other ? (owner ? OWN0 : OWN1) : IDLE;
            else if (other && 32'(hold_cnt) + 1 >= HOLD_FRAMES)
                state_nx = owner ? OWN0 : OWN1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            digit      <= '0;
            hold_cnt   <= '0;
            rr_last    <= 1'b1;
            live       <= 1'b0;
            anodes     <= 4'hF;
            cathodes   <= 8'hFF;
            frame_done <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            presc      <= '0;
            digit      <= '0;
            hold_cnt   <= '0;
            live       <= 1'b0;
            anodes     <= 4'hF;
            cathodes   <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            digit      <= tick ? digit + 2'd1 : digit;
            frame_done <= boundary;
            state      <= state_nx;
            if (state_nx != state) begin
                hold_cnt <= '0;
                if (state != IDLE)
                    rr_last <= owner;
            end else if (boundary && state != IDLE && hold_cnt < HW'(HOLD_FRAMES))
                hold_cnt <= hold_cnt + 1'b1;
            live       <= boundary ? state_nx != IDLE : show;
            anodes     <= state == IDLE ? 4'hF : ~(4'b1000 >> digit);
            cathodes   <= show ? seg : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg7_display_scheduler.sv
// tb_seg7_display_scheduler: directed vector table plus randomized run against a reference model
module tb_seg7_display_scheduler;
    localparam int SD = 4;
    localparam int HF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [31:0] pat0 = '0, pat1 = '0;
    logic [1:0]  gnt;
    logic [3:0]  anodes, always_off_an;
    logic [7:0]  cathodes;
    logic        frame_done;

    int passed = 0;
    int total = 0;

    seg7_display_scheduler #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .pat0(pat0), .pat1(pat1),
        .gnt(gnt), .anodes(anodes), .cathodes(cathodes),
        .always_off_an(always_off_an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic       en;
        logic [1:0] req;
        int         n;
        logic [1:0] gnt;
        logic [3:0] an;
        logic [7:0] cat;
        logic       fd;
    } vec_t;

    vec_t tbl[24];

    // reference model: a frame is a cycle count modulo 4*SD, ownership tracked as an integer
    int         m_c, m_own, m_hold, m_rr, m_live;
    logic [3:0] e_an;
    logic [7:0] e_cat;
    logic       e_fd;

    task automatic model_reset();
        m_c = 0; m_own = -1; m_hold = 0; m_rr = 1; m_live = 0;
        e_an = 4'hF; e_cat = 8'hFF; e_fd = 1'b0;
    endtask

    task automatic model_step();
        int d, no, j;
        bit bnd, show;
        logic [31:0] p;
        if (!en) begin
            m_c = 0; m_own = -1; m_hold = 0; m_live = 0;
            e_an = 4'hF; e_cat = 8'hFF; e_fd = 1'b0;
            return;
        end
        d = (m_c / SD) % 4;
        bnd = (m_c % (4 * SD)) == 4 * SD - 1;
        p = (m_own == 1) ? pat1 : pat0;
        show = 0;
        if (m_own >= 0) show = (m_live != 0) && req[m_own];
        e_fd = bnd;
        e_an = (m_own < 0) ? 4'hF : ~(4'b1000 >> d);
        e_cat = show ? p[31 - 8 * d -: 8] : 8'hFF;
        no = m_own;
        if (m_own < 0) begin
            if (req == 2'b11) no = 1 - m_rr;
            else if (req[0]) no = 0;
            else if (req[1]) no = 1;
        end else if (bnd) begin
            j = 1 - m_own;
            if (!req[m_own]) no = req[j] ? j : -1;
            else if (req[j] && m_hold + 1 >= HF) no = j;
        end
        if (no != m_own) begin
            if (m_own >= 0) m_rr = m_own;
            m_hold = 0;
        end else if (bnd && m_own >= 0 && m_hold < HF) m_hold++;
        m_live = bnd ? int'(no >= 0) : int'(show);
        m_own = no;
        m_c = (m_c + 1) % (4 * SD);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 16, 2'b00, 4'hF, 8'hFF, 1'b1};
        tbl[1]  = '{1'b1, 2'b01,  1, 2'b01, 4'hF, 8'hFF, 1'b0};
        tbl[2]  = '{1'b1, 2'b01,  1, 2'b01, 4'h7, 8'hFF, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 15, 2'b01, 4'h7, 8'hA3, 1'b0};
        tbl[4]  = '{1'b1, 2'b01,  4, 2'b01, 4'hB, 8'h5C, 1'b0};
        tbl[5]  = '{1'b1, 2'b01,  4, 2'b01, 4'hD, 8'h12, 1'b0};
        tbl[6]  = '{1'b1, 2'b01,  4, 2'b01, 4'hE, 8'hF0, 1'b0};
        tbl[7]  = '{1'b1, 2'b01,  3, 2'b01, 4'hE, 8'hF0, 1'b1};
        tbl[8]  = '{1'b1, 2'b01,  5, 2'b01, 4'hB, 8'h5C, 1'b0};
        tbl[9]  = '{1'b1, 2'b10,  1, 2'b01, 4'hB, 8'hFF, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 10, 2'b10, 4'hE, 8'hFF, 1'b1};
        tbl[11] = '{1'b1, 2'b10,  1, 2'b10, 4'h7, 8'h11, 1'b0};
        tbl[12] = '{1'b1, 2'b11, 15, 2'b10, 4'hE, 8'h44, 1'b1};
        tbl[13] = '{1'b1, 2'b11, 15, 2'b10, 4'hE, 8'h44, 1'b0};
        tbl[14] = '{1'b1, 2'b11,  1, 2'b01, 4'hE, 8'h44, 1'b1};
        tbl[15] = '{1'b1, 2'b11,  1, 2'b01, 4'h7, 8'hA3, 1'b0};
        tbl[16] = '{1'b1, 2'b11, 31, 2'b10, 4'hE, 8'hF0, 1'b1};
        tbl[17] = '{1'b1, 2'b11,  9, 2'b10, 4'hD, 8'h33, 1'b0};
        tbl[18] = '{1'b0, 2'b11,  1, 2'b00, 4'hF, 8'hFF, 1'b0};
        tbl[19] = '{1'b0, 2'b11,  3, 2'b00, 4'hF, 8'hFF, 1'b0};
        tbl[20] = '{1'b1, 2'b11,  1, 2'b10, 4'hF, 8'hFF, 1'b0};
        tbl[21] = '{1'b1, 2'b11,  1, 2'b10, 4'h7, 8'hFF, 1'b0};
        tbl[22] = '{1'b1, 2'b11, 14, 2'b10, 4'hE, 8'hFF, 1'b1};
        tbl[23] = '{1'b1, 2'b11,  1, 2'b10, 4'h7, 8'h11, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {gnt, anodes, cathodes, frame_done, always_off_an}, {2'b00, 4'hF, 8'hFF, 1'b0, 4'hF});
        rst_n = 1'b1;
        pat0 = 32'hA35C12F0;
        pat1 = 32'h11223344;
        for (int k = 0; k < 24; k++) begin
            en = tbl[k].en;
            req = tbl[k].req;
            repeat (tbl[k].n) @(posedge clk);
            #1;
            chk($sformatf("vec%0d", k), {gnt, anodes, cathodes, frame_done},
                {tbl[k].gnt, tbl[k].an, tbl[k].cat, tbl[k].fd});
        end

        rst_n = 1'b0;
        #2;
        chk("async_reset", {gnt, anodes, cathodes, frame_done, always_off_an}, {2'b00, 4'hF, 8'hFF, 1'b0, 4'hF});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        req = 2'b11;
        model_reset();
        model_step();
        @(posedge clk);
        #1;
        chk("tie_src0", {30'd0, gnt}, 32'd1);

        for (int i = 0; i < 800; i++) begin
            chk("rand_out", {gnt, anodes, cathodes, frame_done, always_off_an},
                {(m_own == 1) ? 2'b10 : (m_own == 0) ? 2'b01 : 2'b00, e_an, e_cat, e_fd, 4'hF});
            if ($urandom_range(0, 15) == 0) req = 2'($urandom_range(0, 3));
            en = $urandom_range(0, 63) != 0;
            if ($urandom_range(0, 31) == 0) pat0 = $urandom;
            if ($urandom_range(0, 31) == 0) pat1 = $urandom;
            model_step();
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
